lfsr_prbs_checker: RTL and testbench
====================================

// Module: lfsr_prbs_checker
// PURPOSE
//  Receive-side partner of the Galois LFSR sequence generator. Takes the serial
//  bit stream from the generator, self-synchronises to it and locks. It then
//  runs a free-running flywheel predictor and counts bit errors. It sits at the
//  sink end of a PRBS link/loopback used for BIST and link bring-up.
// PARAMETERS
//  LENGTH      8            LFSR length L (>=3), same as the generator
//  TAP_COEFF   8'b1100_1111 generator tap vector [L:1]; bit L is ignored
//  LOCK_CNT    16           consecutive correct predictions needed to lock
//  WIN         64           loss-detection window, in valid bits
//  LOSS_THRESH 8            mismatches within one window that force re-hunt
//  ERR_W       16           err_cnt width
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  din        in   1      received bit = generator Y[L], sampled before its update
//  din_valid  in   1      din qualifier; state advances only when high
//  clr_err    in   1      synchronous clear of err_cnt
//  locked     out  1      checker is in LOCKED
//  err_pulse  out  1      one-cycle pulse per counted mismatch
//  err_cnt    out  ERR_W  saturating error count, LOCKED state only
//  sync_loss  out  1      one-cycle pulse on LOCKED->HUNT
// BEHAVIOUR
//  - History H[L:1]: H[1] is the newest bit. Prediction p = XOR over k=1..L-1 of
//    (TAP_COEFF[k] & H[k]), XOR H[L]. This is exactly the generator recurrence.
//  - States: HUNT, LOCKED. Reset: HUNT, H=0, fill=0, match=0, win=0, miss=0.
//    All outputs reset to 0.
//  - HUNT, per valid bit:
//    - H shifts in din.
//    - While fill<L, fill increments and no compare is made.
//    - Once fill==L: din==p increments match; din!=p clears match.
//    - When match reaches LOCK_CNT, go to LOCKED on that edge. locked is high
//      from the next cycle. win and miss are cleared.
//  - LOCKED (flywheel), per valid bit:
//    - H shifts in p, not din, so one line error counts as exactly one error.
//    - din!=p: err_pulse=1 next cycle, err_cnt+1 (holds at all-ones), miss+1.
//    - win increments. On the WIN-th bit: if miss (including this bit)
//      >= LOSS_THRESH, go to HUNT. Otherwise win and miss clear.
//    - Reaching LOSS_THRESH before window end also goes to HUNT immediately.
//    - LOCKED->HUNT: sync_loss pulses next cycle, fill and match clear,
//      err_cnt holds.
//  - din_valid=0: nothing advances. err_pulse and sync_loss are 0 that cycle.
//  - clr_err together with an error on the same edge: clear wins, err_cnt=0.
//  - Latency: err_pulse and locked are registered, 1 cycle after the bit's edge.
//  - rst asserted mid-stream: immediate return to the reset state.
// CONFIGURATION
//  LFSR_ZERO_GUARD_EN:
//  - Defined: in HUNT, a compare with H==0 and din==0 clears match instead of
//    incrementing it, so an all-zero (dead) stream can never lock.
//  - Undefined: all-zero input is a legal fixed point of the recurrence. It
//    locks after L+LOCK_CNT zero bits and reports no errors.
// TESTING
//  1 Generator (L=8, taps 8'hCF, seed 8'h91) drives din with din_valid=1
//    -> locked rises after bit 8+16=24, err_cnt stays 0 for 1000 bits.
//  2 After lock, flip a single din bit -> exactly one err_pulse, err_cnt=1,
//    locked stays high.
//  3 After lock, flip 8 bits within 64 -> sync_loss pulses, locked falls,
//    relock within 24 further clean bits, err_cnt=8.
//  4 Toggle din_valid randomly (50%) with the generator stalled in step
//    -> lock at the 24th valid bit, zero errors.
//  5 din=0 constant: macro defined -> locked stays 0 for 500 bits; macro
//    undefined -> locked=1 after 24 bits.
//  6 Force err_cnt to all-ones with ERR_W=4 -> holds at 15; clr_err plus an
//    error on the same edge -> 0. Assert rst mid-lock -> all outputs 0.

Source files
------------

// File: rtl/lfsr_prbs_checker.sv
// lfsr_prbs_checker: self-synchronising PRBS checker with flywheel predictor and error counter; LFSR_ZERO_GUARD_EN blocks lock on an all-zero stream
module lfsr_prbs_checker #(
  parameter int LENGTH = 8,
  parameter logic [LENGTH:1] TAP_COEFF = 8'b1100_1111,
  parameter int LOCK_CNT = 16,
  parameter int WIN = 64,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             sync_loss
);
  localparam int FW = $clog2(LENGTH + 1);
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN + 1);
  localparam int MW = $clog2(LOSS_THRESH + 1);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state_q, state_d;
  logic [LENGTH:1] h_q, h_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [CW-1:0] match_q, match_d;
  logic [WW-1:0] win_q, win_d;
  logic [MW-1:0] miss_q, miss_d, miss_n;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic err_pulse_q, err_pulse_d, sync_loss_q, sync_loss_d;
  logic p, mis, hit, full;
  // HUNT trains on din until LOCK_CNT straight hits; LOCKED flywheels on its own prediction
  always_comb begin
    p = ^(TAP_COEFF[LENGTH-1:1] & h_q[LENGTH-1:1]) ^ h_q[LENGTH];
    mis = din != p;
`ifdef LFSR_ZERO_GUARD_EN
    hit = !mis && (din || |h_q);
`else
    hit = !mis;
`endif
    full = fill_q == FW'(LENGTH);
    miss_n = miss_q + MW'(mis);
    state_d = state_q;
    h_d = h_q;
    fill_d = fill_q;
    match_d = match_q;
    win_d = win_q;
    miss_d = miss_q;
    err_cnt_d = err_cnt_q;
    err_pulse_d = 1'b0;
    sync_loss_d = 1'b0;
    if (din_valid && state_q == HUNT) begin
      h_d = {h_q[LENGTH-1:1], din};
      fill_d = full ? fill_q : fill_q + 1'b1;
      match_d = !full ? match_q : hit ? match_q + 1'b1 : '0;
      if (full && hit && match_q == CW'(LOCK_CNT - 1)) begin
        state_d = LOCKED;
        match_d = '0;
        win_d = '0;
        miss_d = '0;
      end
    end else if (din_valid) begin
      h_d = {h_q[LENGTH-1:1], p};
      err_pulse_d = mis;
      err_cnt_d = mis && !(&err_cnt_q) ? err_cnt_q + 1'b1 : err_cnt_q;
      if (miss_n >= MW'(LOSS_THRESH)) begin
        state_d = HUNT;
        sync_loss_d = 1'b1;
        fill_d = '0;
        match_d = '0;
        win_d = '0;
        miss_d = '0;
      end else begin
        win_d = win_q == WW'(WIN - 1) ? '0 : win_q + 1'b1;
        miss_d = win_q == WW'(WIN - 1) ? '0 : miss_n;
      end
    end
    if (clr_err) err_cnt_d = '0;
  end
  // state and history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      h_q <= '0;
      fill_q <= '0;
      match_q <= '0;
      win_q <= '0;
      miss_q <= '0;
      err_cnt_q <= '0;
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      fill_q <= fill_d;
      match_q <= match_d;
      win_q <= win_d;
      miss_q <= miss_d;
      err_cnt_q <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      sync_loss_q <= sync_loss_d;
    end
  end
  assign locked = state_q == LOCKED;
  assign err_pulse = err_pulse_q;
  assign sync_loss = sync_loss_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// tb_lfsr_prbs_checker: table-driven scenarios with a per-cycle scoreboard fed by a reference model
module tb_lfsr_prbs_checker;
`ifdef LFSR_ZERO_GUARD_EN
  localparam bit ZG = 1'b1;
`else
  localparam bit ZG = 1'b0;
`endif
  localparam logic [8:1] TAP = 8'hCF;
  logic clk, rst, din, din_valid, clr_err, locked, err_pulse, sync_loss;
  logic [3:0] err_cnt;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic l, ep, sl; logic [3:0] ec;} out_t;
  typedef struct {
    string name;
    bit do_rst, do_clr, zero;
    int nbits, valid_pct, flip_start, nflips, spacing, lock_at, exp_err, exp_loss;
    bit exp_locked;
  } vec_t;
  out_t sb[$];
  vec_t tbl[7];
  logic [8:1] g, mh;
  logic ml, m_ep, m_sl;
  logic [3:0] m_err;
  int mfill, mmatch, mwin, mmiss;

  lfsr_prbs_checker #(.LENGTH(8), .TAP_COEFF(8'hCF), .LOCK_CNT(16), .WIN(64),
                      .LOSS_THRESH(8), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .sync_loss(sync_loss));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  function automatic logic gen_bit();
    logic b;
    b = ^(TAP[7:1] & g[7:1]) ^ g[8];
    g = {g[7:1], b};
    return b;
  endfunction

  function automatic void model_reset();
    mh = '0; ml = 0; m_ep = 0; m_sl = 0; m_err = '0;
    mfill = 0; mmatch = 0; mwin = 0; mmiss = 0;
  endfunction

  function automatic void model(logic d, logic v, logic c);
    logic p;
    m_ep = 0;
    m_sl = 0;
    if (v) begin
      p = ^(TAP[7:1] & mh[7:1]) ^ mh[8];
      if (!ml) begin
        if (mfill < 8) mfill++;
        else if (d == p && !(ZG && mh == 0 && !d)) mmatch++;
        else mmatch = 0;
        mh = {mh[7:1], d};
        if (mmatch == 16) begin ml = 1; mmatch = 0; mwin = 0; mmiss = 0; end
      end else begin
        mh = {mh[7:1], p};
        if (d != p) begin
          m_ep = 1;
          if (m_err != 4'hF) m_err++;
          mmiss++;
        end
        mwin++;
        if (mmiss >= 8) begin
          ml = 0; m_sl = 1; mfill = 0; mmatch = 0; mwin = 0; mmiss = 0;
        end else if (mwin == 64) begin
          mwin = 0; mmiss = 0;
        end
      end
    end
    if (c) m_err = '0;
  endfunction

  task automatic tick(input logic d, input logic v, input logic c);
    out_t e, a;
    din = d; din_valid = v; clr_err = c;
    model(d, v, c);
    sb.push_back({ml, m_ep, m_sl, m_err});
    @(posedge clk); #1;
    e = sb.pop_front();
    a = {locked, err_pulse, sync_loss, err_cnt};
    check("cycle", 32'(a), 32'(e));
  endtask

  task automatic do_reset();
    rst = 1; din = 0; din_valid = 0; clr_err = 0;
    @(posedge clk); #1;
    check("reset_outs", {28'd0, locked, err_pulse, sync_loss, |err_cnt}, 0);
    rst = 0;
    model_reset();
    g = 8'h91;
  endtask

  function automatic vec_t mk(string n, bit r, bit c, int nb, bit z, int vp, int fs, int nf,
                              int sp, int la, bit el, int ee, int eloss);
    vec_t t;
    t.name = n; t.do_rst = r; t.do_clr = c; t.nbits = nb; t.zero = z; t.valid_pct = vp;
    t.flip_start = fs; t.nflips = nf; t.spacing = sp; t.lock_at = la;
    t.exp_locked = el; t.exp_err = ee; t.exp_loss = eloss;
    return t;
  endfunction

  task automatic run(input vec_t t);
    int n, first_lock, losses;
    logic b, f;
    if (t.do_rst) do_reset();
    if (t.do_clr) tick(1'b0, 1'b0, 1'b1);
    n = 0; first_lock = 0; losses = 0;
    while (n < t.nbits) begin
      if ($urandom_range(99) >= t.valid_pct) begin
        tick(1'($urandom_range(1)), 1'b0, 1'b0);
        losses += int'(sync_loss);
        continue;
      end
      n++;
      b = t.zero ? 1'b0 : gen_bit();
      f = t.nflips > 0 && n >= t.flip_start && (n - t.flip_start) % t.spacing == 0 &&
          (n - t.flip_start) / t.spacing < t.nflips;
      tick(b ^ f, 1'b1, 1'b0);
      if (locked && first_lock == 0) first_lock = n;
      losses += int'(sync_loss);
    end
    if (t.lock_at >= 0) check({t.name, "_lock_at"}, first_lock, t.lock_at);
    check({t.name, "_locked"}, 32'(locked), 32'(t.exp_locked));
    check({t.name, "_err_cnt"}, 32'(err_cnt), t.exp_err);
    check({t.name, "_sync_loss"}, losses, t.exp_loss);
  endtask

  initial begin
    rst = 1; din = 0; din_valid = 0; clr_err = 0; g = 8'h91;
    model_reset();
    tbl[0] = mk("clean", 1, 0, 1000, 0, 100, 0, 0, 1, 24, 1, 0, 0);
    tbl[1] = mk("flip1", 0, 1, 100, 0, 100, 10, 1, 1, -1, 1, 1, 0);
    tbl[2] = mk("flip8", 1, 0, 150, 0, 100, 30, 8, 1, 24, 1, 8, 1);
    tbl[3] = mk("stall", 1, 0, 200, 0, 50, 0, 0, 1, 24, 1, 0, 0);
    tbl[4] = mk("flip7", 1, 0, 200, 0, 100, 30, 7, 1, 24, 1, 7, 0);
    tbl[5] = mk("zero", 1, 0, 500, 1, 100, 0, 0, 1, ZG ? 0 : 24, !ZG, 0, 0);
    tbl[6] = mk("sat", 1, 0, 250, 0, 100, 30, 17, 10, 24, 1, 15, 0);
    for (int i = 0; i < 7; i++) run(tbl[i]);
    tick(gen_bit() ^ 1'b1, 1'b1, 1'b1);
    check("clr_wins", 32'(err_cnt), 0);
    check("clr_pulse", 32'(err_pulse), 1);
    #2 rst = 1;
    #1 check("rst_async", 32'({locked, err_pulse, sync_loss, err_cnt}), 0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
